// File: rtl/axis_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : axis_decimator
//  Purpose  : AXI-Stream block-averaging decimator (mean of 2^R samples),
//             with one-cycle pass-through when disabled.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_decimator #(
   parameter int AXIS_TDATA_WIDTH = 16,
   parameter int MAX_LOG2_RATE    = 8
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        enable,
   input  logic [3:0]                  log2_rate,
   input  logic                        S_AXIS_tvalid,
   input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
   output logic                        S_AXIS_tready,
   input  logic                        M_AXIS_tready,
   output logic                        M_AXIS_tvalid,
   output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

   localparam int c_ACC_W = AXIS_TDATA_WIDTH + MAX_LOG2_RATE;
   localparam int c_CNT_W = MAX_LOG2_RATE + 1;

   logic signed [c_ACC_W-1:0]          acc_q, acc_d;
   logic [c_CNT_W-1:0]                 cnt_q, cnt_d;
   logic [3:0]                         rate_q, rate_d;
   logic [AXIS_TDATA_WIDTH-1:0]        out_data_q, out_data_d;
   logic                               out_valid_q, out_valid_d;

   logic [3:0]                         eff_rate;
   logic [3:0]                         rate_use;
   logic [c_CNT_W-1:0]                 cnt_last;
   logic signed [c_ACC_W-1:0]          base;
   logic signed [c_ACC_W-1:0]          sum;
   logic [AXIS_TDATA_WIDTH-1:0]        mean;
   logic                               block_start;
   logic                               block_done;
   logic                               accept;
   logic                               xfer;

   assign S_AXIS_tready = aresetn & (~out_valid_q | M_AXIS_tready);
   assign M_AXIS_tvalid = out_valid_q;
   assign M_AXIS_tdata  = out_data_q;

   assign accept = S_AXIS_tvalid & S_AXIS_tready;
   assign xfer   = out_valid_q & M_AXIS_tready;

   assign eff_rate    = !enable ? 4'd0 :
                        (int'(log2_rate) > MAX_LOG2_RATE) ? 4'(MAX_LOG2_RATE) : log2_rate;
   assign block_start = (cnt_q == '0);
   // The rate is latched at block start so mid-block changes apply to the next block.
   assign rate_use    = block_start ? eff_rate : rate_q;
   assign cnt_last    = (c_CNT_W'(1) << rate_use) - c_CNT_W'(1);
   assign block_done  = (cnt_q == cnt_last);
   assign base        = block_start ? '0 : acc_q;
   assign sum         = base + {{MAX_LOG2_RATE{S_AXIS_tdata[AXIS_TDATA_WIDTH-1]}}, S_AXIS_tdata};
   assign mean        = AXIS_TDATA_WIDTH'(sum >>> rate_use);

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      rate_d      = rate_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      if (xfer) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (block_start) begin
            rate_d = eff_rate;
         end
         if (block_done) begin
            out_data_d  = mean;
            out_valid_d = 1'b1;
            cnt_d       = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + c_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         rate_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         rate_q      <= rate_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_decimator
//  Purpose  : Self-checking bench for axis_decimator against a sample-count /
//             floor-division model plus hand-computed output sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_decimator;

   localparam int c_W    = 16;
   localparam int c_MAXR = 8;

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic             enable = 1'b0;
   logic [3:0]       log2_rate = 4'd0;
   logic             S_AXIS_tvalid = 1'b0;
   logic [c_W-1:0]   S_AXIS_tdata = '0;
   logic             S_AXIS_tready;
   logic             M_AXIS_tready = 1'b0;
   logic             M_AXIS_tvalid;
   logic [c_W-1:0]   M_AXIS_tdata;

   int               n_cmp = 0;
   int               n_bad = 0;

   // model state
   bit               m_valid = 1'b0;
   longint           m_data  = 0;
   int               m_cnt   = 0;
   int               m_rate  = 0;
   longint           m_sum   = 0;

   logic [c_W-1:0]   obs[$];

   axis_decimator #(
      .AXIS_TDATA_WIDTH(c_W),
      .MAX_LOG2_RATE   (c_MAXR)
   ) u_dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .enable       (enable),
      .log2_rate    (log2_rate),
      .S_AXIS_tvalid(S_AXIS_tvalid),
      .S_AXIS_tdata (S_AXIS_tdata),
      .S_AXIS_tready(S_AXIS_tready),
      .M_AXIS_tready(M_AXIS_tready),
      .M_AXIS_tvalid(M_AXIS_tvalid),
      .M_AXIS_tdata (M_AXIS_tdata)
   );

   always #5 aclk = ~aclk;

   function automatic longint floordiv(input longint s, input int r);
      longint d;
      longint q;
      d = longint'(1) << r;
      q = s / d;
      if ((s % d) != 0 && s < 0) q = q - 1;
      return q;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Mean of each block of 2^R accepted samples, floor-rounded.
   always @(posedge aclk or negedge aresetn) begin : mdl
      bit     v;
      bit     rdy;
      int     c;
      int     r;
      longint s;
      longint d;
      if (!aresetn) begin
         m_valid <= 1'b0;
         m_data  <= 0;
         m_cnt   <= 0;
         m_rate  <= 0;
         m_sum   <= 0;
      end else begin
         v   = m_valid;
         c   = m_cnt;
         r   = m_rate;
         s   = m_sum;
         d   = m_data;
         rdy = !v || M_AXIS_tready;
         if (v && M_AXIS_tready) v = 1'b0;
         if (S_AXIS_tvalid && rdy) begin
            if (c == 0) begin
               r = enable ? ((int'(log2_rate) > c_MAXR) ? c_MAXR : int'(log2_rate)) : 0;
               s = 0;
            end
            s = s + longint'($signed(S_AXIS_tdata));
            c = c + 1;
            if (c == (1 << r)) begin
               d = floordiv(s, r);
               v = 1'b1;
               c = 0;
            end
         end
         m_valid <= v;
         m_cnt   <= c;
         m_rate  <= r;
         m_sum   <= s;
         m_data  <= d;
      end
   end

   always @(negedge aclk) begin : cmp
      logic [63:0] md;
      md = m_data;
      chk("tvalid", {31'd0, M_AXIS_tvalid}, {31'd0, m_valid});
      chk("tdata", {16'd0, M_AXIS_tdata}, {16'd0, md[c_W-1:0]});
      chk("s_tready", {31'd0, S_AXIS_tready}, {31'd0, aresetn && (!m_valid || M_AXIS_tready)});
      if (aresetn && M_AXIS_tvalid && M_AXIS_tready) obs.push_back(M_AXIS_tdata);
   end

   task automatic idle(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [c_W-1:0] d);
      bit ok;
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = d;
      for (int k = 0; k < 1000; k++) begin
         @(negedge aclk);
         ok = S_AXIS_tready;
         @(posedge aclk);
         #1;
         if (ok) break;
         if (k == 999) chk("send_timeout", 32'd1, 32'd0);
      end
      S_AXIS_tvalid = 1'b0;
   endtask

   task automatic expect_obs(input string nm, input int n,
                             input logic [c_W-1:0] e0, input logic [c_W-1:0] e1,
                             input logic [c_W-1:0] e2);
      logic [c_W-1:0] e[3];
      e = '{e0, e1, e2};
      chk({nm, "_count"}, 32'(obs.size()), 32'(n));
      for (int i = 0; i < n && i < obs.size(); i++)
         chk(nm, {16'd0, obs[i]}, {16'd0, e[i]});
      obs.delete();
   endtask

   initial begin
      // reset with input asserted
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = 16'h0123;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
      chk("rst_tdata", {16'd0, M_AXIS_tdata}, 32'd0);
      chk("rst_s_tready", {31'd0, S_AXIS_tready}, 32'd0);
      @(posedge aclk);
      #1;
      S_AXIS_tvalid = 1'b0;
      M_AXIS_tready = 1'b1;
      aresetn       = 1'b1;
      @(negedge aclk);
      chk("rel_s_tready", {31'd0, S_AXIS_tready}, 32'd1);
      idle(1);

      // R=2 average, then R=1 negative
      enable    = 1'b1;
      log2_rate = 4'd2;
      send(16'd4); send(16'd8); send(16'd12); send(16'd16);
      idle(3);
      expect_obs("avg_r2", 1, 16'd10, 16'd0, 16'd0);
      log2_rate = 4'd1;
      send(16'hFFFD); send(16'hFFFE);
      idle(3);
      expect_obs("avg_r1_neg", 1, 16'hFFFD, 16'd0, 16'd0);

      // full scale at R=8
      log2_rate = 4'd8;
      for (int i = 0; i < 256; i++) send(16'h7FFF);
      idle(3);
      expect_obs("fs_pos", 1, 16'h7FFF, 16'd0, 16'd0);
      for (int i = 0; i < 256; i++) send(16'h8000);
      idle(3);
      expect_obs("fs_neg", 1, 16'h8000, 16'd0, 16'd0);

      // requested 15 clamps to 8: (255*4 + 256) / 256 = 4, with an idle gap mid-block
      log2_rate = 4'd15;
      for (int i = 0; i < 255; i++) send(16'd4);
      idle(4);
      expect_obs("clamp_partial", 0, 16'd0, 16'd0, 16'd0);
      send(16'h0100);
      idle(3);
      expect_obs("clamp", 1, 16'd4, 16'd0, 16'd0);

      // bypass
      enable = 1'b0;
      send(16'h7FFF); send(16'h0001); send(16'hFFFE);
      idle(3);
      expect_obs("bypass", 3, 16'h7FFF, 16'h0001, 16'hFFFE);

      // backpressure at R=0
      enable        = 1'b1;
      log2_rate     = 4'd0;
      M_AXIS_tready = 1'b0;
      send(16'd5);
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = 16'd6;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("bp_s_tready", {31'd0, S_AXIS_tready}, 32'd0);
      chk("bp_hold_valid", {31'd0, M_AXIS_tvalid}, 32'd1);
      chk("bp_hold_data", {16'd0, M_AXIS_tdata}, 32'd5);
      @(posedge aclk);
      #1;
      M_AXIS_tready = 1'b1;
      @(posedge aclk);
      #1;
      S_AXIS_tvalid = 1'b0;
      idle(3);
      expect_obs("backpressure", 2, 16'd5, 16'd6, 16'd0);

      // rate change mid-block: (1+2+3+4)/4 = 2, then single samples
      log2_rate = 4'd2;
      send(16'd1); send(16'd2);
      log2_rate = 4'd0;
      send(16'd3); send(16'd4);
      send(16'd7); send(16'hFFF9);
      idle(3);
      expect_obs("rate_change", 3, 16'd2, 16'd7, 16'hFFF9);

      // reset mid-block discards the partial sum
      log2_rate = 4'd2;
      send(16'd9); send(16'd9); send(16'd9);
      #2 aresetn = 1'b0;
      @(posedge aclk);
      #1 aresetn = 1'b1;
      idle(3);
      expect_obs("rst_mid", 0, 16'd0, 16'd0, 16'd0);
      send(16'd1); send(16'd1); send(16'd1); send(16'd1);
      idle(3);
      expect_obs("after_rst", 1, 16'd1, 16'd0, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
